// File: rtl/grf_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
// Holds default widths, the zero-register index and the write-forwarding
// selector used by both the read mux and the hazard logic.
package grf_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int ZERO_REG = 0;

    // The forwarding selector works on zero-padded vectors so one function
    // serves every parameterisation up to 16 write ports and 16 address bits.
    localparam int FWD_AW = 16;
    localparam int FWD_NW = 16;
    localparam int FWD_IW = 4;

    typedef struct packed {
        logic              hit;
        logic [FWD_IW-1:0] idx;
    } fwd_t;

    // Returns whether any enabled write port targets addr, and which port
    // wins; later ports overwrite earlier matches so the highest index wins.
    function automatic fwd_t fwd_sel(
        input logic [FWD_AW-1:0]        addr,
        input logic [FWD_NW-1:0]        we,
        input logic [FWD_NW*FWD_AW-1:0] waddr
    );
        fwd_t res;
        res.hit = 1'b0;
        res.idx = '0;
        for (int j = 0; j < FWD_NW; j++) begin
            if (we[j] && (waddr[j*FWD_AW +: FWD_AW] == addr)) begin
                res.hit = 1'b1;
                res.idx = FWD_IW'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Busy is set when a destination issues and cleared at writeback or flush;
// a same-cycle issue always wins. A register being written back this cycle
// is not reported busy because its value is forwarded on the read path.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int NW = 2,
    parameter int NR = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NW-1:0]   we,
    input  logic [NW*AW-1:0] waddr,
    input  logic            issue_vld,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR-1:0]   rbusy
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0]         r_busy;
    logic [DEPTH-1:0]         w_busyNext;
    logic [FWD_NW-1:0]        w_wePad;
    logic [FWD_NW*FWD_AW-1:0] w_waddrPad;

    // Widen the write-port vectors to the shape the forwarding selector expects
    always_comb begin
        w_wePad    = '0;
        w_waddrPad = '0;
        for (int j = 0; j < NW; j++) begin
            w_wePad[j]                        = we[j];
            w_waddrPad[j*FWD_AW +: FWD_AW]    = FWD_AW'(waddr[j*AW +: AW]);
        end
    end

    // Next busy state: flush first, then writeback clears, then issue sets
    always_comb begin
        w_busyNext = r_busy;
        if (flush) begin
            w_busyNext = '0;
        end
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                w_busyNext[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (issue_vld) begin
            w_busyNext[issue_addr] = 1'b1;
        end
        w_busyNext[ZERO_REG] = 1'b0;
    end

    // Busy vector register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // Per read port hazard: busy, not being written back now, and not $0
    always_comb begin
        logic [AW-1:0] addr;
        fwd_t          w_unusedSel;
        rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            addr        = raddr[i*AW +: AW];
            w_unusedSel = fwd_sel(FWD_AW'(addr), w_wePad, w_waddrPad);
            rbusy[i]    = r_busy[addr] & ~w_unusedSel.hit & (addr != AW'(ZERO_REG));
        end
    end

endmodule

// File: rtl/grf_mp_sb.sv
// Multi-port general register file with write-through forwarding and a
// pending-write scoreboard. Register 0 always reads zero. Higher-index write
// ports win collisions both in storage and on the forwarding path.
// Optional feature: define GRF_TRACE_EN to print one line per effective write.
module grf_mp_sb
    import grf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NR = 2,
    parameter int NW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NW*32-1:0] wpc,
    input  logic             issue_vld,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]            w_regs [DEPTH];
    logic [FWD_NW-1:0]        w_wePad;
    logic [FWD_NW*FWD_AW-1:0] w_waddrPad;

    // One storage register per address; $0 is a constant zero
    for (genvar r = 0; r < DEPTH; r++) begin : gen_reg
        if (r == ZERO_REG) begin : gen_zero
            assign w_regs[r] = '0;
        end else begin : gen_store
            logic [DW-1:0] r_q;

            // Capture the highest-index write port that targets this register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else begin
                    for (int j = 0; j < NW; j++) begin
                        if (we[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                            r_q <= wdata[j*DW +: DW];
                        end
                    end
                end
            end

            assign w_regs[r] = r_q;
        end
    end

    // Widen write ports for the selector; forwarding is disabled during reset
    always_comb begin
        w_wePad    = '0;
        w_waddrPad = '0;
        for (int j = 0; j < NW; j++) begin
            w_wePad[j]                     = we[j] & rst_n;
            w_waddrPad[j*FWD_AW +: FWD_AW] = FWD_AW'(waddr[j*AW +: AW]);
        end
    end

    // Read mux: zero register, else forwarded write data, else stored value
    always_comb begin
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
        fwd_t          sel;
        rdata = '0;
        for (int i = 0; i < NR; i++) begin
            addr = raddr[i*AW +: AW];
            sel  = fwd_sel(FWD_AW'(addr), w_wePad, w_waddrPad);
            val  = w_regs[addr];
            if (sel.hit) begin
                for (int j = 0; j < NW; j++) begin
                    if (FWD_IW'(j) == sel.idx) begin
                        val = wdata[j*DW +: DW];
                    end
                end
            end
            if (addr == AW'(ZERO_REG)) begin
                val = '0;
            end
            rdata[i*DW +: DW] = val;
        end
    end

    grf_scoreboard #(
        .AW (AW),
        .NW (NW),
        .NR (NR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .issue_vld  (issue_vld),
        .issue_addr (issue_addr),
        .flush      (flush),
        .raddr      (raddr),
        .rbusy      (rbusy)
    );

`ifdef GRF_TRACE_EN
    // Log each write that lands; ports shadowed by a higher port stay silent
    always @(posedge clk) begin
        logic shadow;
        if (rst_n) begin
            for (int j = 0; j < NW; j++) begin
                shadow = 1'b0;
                for (int k = j + 1; k < NW; k++) begin
                    if (we[k] && (waddr[k*AW +: AW] == waddr[j*AW +: AW])) begin
                        shadow = 1'b1;
                    end
                end
                if (we[j] && (waddr[j*AW +: AW] != AW'(ZERO_REG)) && !shadow) begin
                    $display("%d@%h: $%d <= %h", $time, wpc[j*32 +: 32] - 32'd8,
                             waddr[j*AW +: AW], wdata[j*DW +: DW]);
                end
            end
        end
    end
`else
    logic w_unusedWpc;
    assign w_unusedWpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_mp_sb.sv
// Directed bench for grf_mp_sb with the default 32x32, 2-read/2-write setup.
// Inputs change just after the falling edge; combinational outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_grf_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW*32-1:0] wpc;
    logic             issue_vld;
    logic [AW-1:0]    issue_addr;
    logic             flush;

    int total = 0;
    int bad   = 0;

    grf_mp_sb #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wpc        (wpc),
        .issue_vld  (issue_vld),
        .issue_addr (issue_addr),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    // Drive every write/issue/flush input for the current cycle
    task automatic applyStimulus(input logic [1:0] weV, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic iv, input logic [4:0] ia, input logic fl);
        we         = weV;
        waddr      = {wa1, wa0};
        wdata      = {wd1, wd0};
        wpc        = {32'h0000_4008, 32'h0000_3008};
        issue_vld  = iv;
        issue_addr = ia;
        flush      = fl;
    endtask

    task automatic setReads(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic idle();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Power-up state, then async reset in the middle of operation
    task automatic test_reset();
        @(negedge clk);
        idle();
        setReads(5'd5, 5'd0);
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL por_rdata: got %h expected %h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL por_rbusy: got %b expected %b", rbusy, 2'b00); end
        applyStimulus(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
        nextCycle();
        idle();
        #1;
        total++; if (rdata[31:0] !== 32'h1234) begin bad++; $display("[TB] FAIL wr5_rdata: got %h expected %h", rdata[31:0], 32'h1234); end
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL wr5_busy: got %b expected %b", rbusy[0], 1'b1); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_async_rdata: got %h expected %h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL rst_async_rbusy: got %b expected %b", rbusy, 2'b00); end
        applyStimulus(2'b01, 5'd5, 32'h9999, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_no_fwd: got %h expected %h", rdata[31:0], 32'h0); end
        @(posedge clk);
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_no_write: got %h expected %h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL rst_no_issue: got %b expected %b", rbusy, 2'b00); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL release_rdata: got %h expected %h", rdata[31:0], 32'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL release_rbusy: got %b expected %b", rbusy, 2'b00); end
    endtask

    // Both ports hitting one register, then two distinct registers
    task automatic test_collision();
        @(negedge clk);
        applyStimulus(2'b11, 5'd7, 32'h0000_AAAA, 5'd7, 32'h0000_BBBB, 1'b0, 5'd0, 1'b0);
        setReads(5'd7, 5'd7);
        #1;
        total++; if (rdata[31:0] !== 32'h0000_BBBB) begin bad++; $display("[TB] FAIL coll_fwd0: got %h expected %h", rdata[31:0], 32'h0000_BBBB); end
        total++; if (rdata[63:32] !== 32'h0000_BBBB) begin bad++; $display("[TB] FAIL coll_fwd1: got %h expected %h", rdata[63:32], 32'h0000_BBBB); end
        nextCycle();
        idle();
        #1;
        total++; if (rdata[31:0] !== 32'h0000_BBBB) begin bad++; $display("[TB] FAIL coll_stored: got %h expected %h", rdata[31:0], 32'h0000_BBBB); end
        applyStimulus(2'b11, 5'd8, 32'h11, 5'd9, 32'h22, 1'b0, 5'd0, 1'b0);
        setReads(5'd9, 5'd8);
        #1;
        total++; if (rdata !== {32'h11, 32'h22}) begin bad++; $display("[TB] FAIL dual_fwd: got %h expected %h", rdata, {32'h11, 32'h22}); end
        nextCycle();
        idle();
        #1;
        total++; if (rdata !== {32'h11, 32'h22}) begin bad++; $display("[TB] FAIL dual_stored: got %h expected %h", rdata, {32'h11, 32'h22}); end
    endtask

    // Writes and issues to $0 have no visible effect
    task automatic test_zero_reg();
        @(negedge clk);
        applyStimulus(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h1357_9BDF, 1'b1, 5'd0, 1'b0);
        setReads(5'd0, 5'd0);
        #1;
        total++; if (rdata !== 64'h0) begin bad++; $display("[TB] FAIL zero_fwd: got %h expected %h", rdata, 64'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL zero_busy_now: got %b expected %b", rbusy, 2'b00); end
        nextCycle();
        idle();
        #1;
        total++; if (rdata !== 64'h0) begin bad++; $display("[TB] FAIL zero_stored: got %h expected %h", rdata, 64'h0); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL zero_busy_next: got %b expected %b", rbusy, 2'b00); end
    endtask

    // Issue at t, busy visible from t+1, writeback at t+3 resolves it
    task automatic test_scoreboard();
        @(negedge clk);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        setReads(5'd3, 5'd0);
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_t0: got %b expected %b", rbusy[0], 1'b0); end
        nextCycle();
        idle();
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_t1: got %b expected %b", rbusy[0], 1'b1); end
        nextCycle();
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_t2: got %b expected %b", rbusy[0], 1'b1); end
        nextCycle();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd3, 32'h42, 1'b0, 5'd0, 1'b0);
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_t3_busy: got %b expected %b", rbusy[0], 1'b0); end
        total++; if (rdata[31:0] !== 32'h42) begin bad++; $display("[TB] FAIL sb_t3_rdata: got %h expected %h", rdata[31:0], 32'h42); end
        nextCycle();
        idle();
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_t4_busy: got %b expected %b", rbusy[0], 1'b0); end
        total++; if (rdata[31:0] !== 32'h42) begin bad++; $display("[TB] FAIL sb_t4_rdata: got %h expected %h", rdata[31:0], 32'h42); end
    endtask

    // Issue wins over a same-cycle writeback and flush; flush clears the rest
    task automatic test_set_wins();
        @(negedge clk);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1);
        setReads(5'd4, 5'd10);
        #1;
        total++; if (rbusy !== 2'b10) begin bad++; $display("[TB] FAIL sw_same_cycle: got %b expected %b", rbusy, 2'b10); end
        nextCycle();
        idle();
        #1;
        total++; if (rbusy !== 2'b01) begin bad++; $display("[TB] FAIL sw_set_wins: got %b expected %b", rbusy, 2'b01); end
        total++; if (rdata[31:0] !== 32'h55) begin bad++; $display("[TB] FAIL sw_rdata: got %h expected %h", rdata[31:0], 32'h55); end
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        nextCycle();
        idle();
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL sw_flush: got %b expected %b", rbusy, 2'b00); end
    endtask

    // Repeated issue to the same register is cleared by a single writeback
    task automatic test_back_to_back();
        @(negedge clk);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        setReads(5'd6, 5'd6);
        nextCycle();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        #1;
        total++; if (rbusy !== 2'b11) begin bad++; $display("[TB] FAIL b2b_busy: got %b expected %b", rbusy, 2'b11); end
        nextCycle();
        applyStimulus(2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL b2b_wb_busy: got %b expected %b", rbusy, 2'b00); end
        total++; if (rdata !== {32'h66, 32'h66}) begin bad++; $display("[TB] FAIL b2b_wb_rdata: got %h expected %h", rdata, {32'h66, 32'h66}); end
        nextCycle();
        idle();
        #1;
        total++; if (rbusy !== 2'b00) begin bad++; $display("[TB] FAIL b2b_no_count: got %b expected %b", rbusy, 2'b00); end
    endtask

    // Hard bound on simulation time in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset, then run each scenario in turn and report
    initial begin
        rst_n = 1'b1;
        idle();
        setReads(5'd0, 5'd0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_set_wins();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
